// File: rtl/pwr_event_sched.sv
// pwr_event_sched
// Round-robin scheduler that shares one read-modify-write incrementer among
// NREQ transition-event sources. Each source's events are buffered in a small
// saturating pending counter. A three-state FSM (IDLE -> READ -> WRITE) drains
// one event at a time into that source's transition counter.
//
// Ports
//   C        in   clock, rising edge
//   R_n      in   asynchronous active-low reset
//   ev       in   [NREQ]   per-source event strobe, one event per cycle per bit
//   clr      in   synchronous clear of counters, pending and overflow state
//   rd_sel   in   [SEL_W]  counter read select
//   rd_data  out  [CNT_W]  cnt[rd_sel], combinational; 0 for rd_sel >= NREQ
//   grant    out  [NREQ]   one-hot source being serviced; 0 when idle
//   busy     out  FSM is not IDLE
//   ovf      out  [NREQ]   sticky overflow: event dropped or counter wrapped
module pwr_event_sched #(
  parameter int NREQ   = 4,
  parameter int CNT_W  = 16,
  parameter int PEND_W = 3,
  parameter int SEL_W  = $clog2(NREQ)
) (
  input  logic              C,
  input  logic              R_n,
  input  logic [NREQ-1:0]   ev,
  input  logic              clr,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [NREQ-1:0]   ovf
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [SEL_W-1:0]  LG_INIT  = SEL_W'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t              state, state_nxt;
  logic [PEND_W-1:0]   pending [NREQ];
  logic [CNT_W-1:0]    cnt     [NREQ];
  logic [CNT_W-1:0]    acc;
  logic [SEL_W-1:0]    cur;
  logic [SEL_W-1:0]    lg;
  logic                found;
  logic [SEL_W-1:0]    pick;
  logic [SEL_W-1:0]    idx;
  logic [NREQ-1:0]     drain;
  logic [CNT_W-1:0]    rd_tab  [2**SEL_W];

  // Saturating pending-counter update; an event and a drain in the same
  // cycle cancel out.
  function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] p,
                                                  input logic e, input logic d);
    if (e && !d)
      pend_next = (p == PEND_MAX) ? p : p + PEND_W'(1);
    else if (d && !e)
      pend_next = p - PEND_W'(1);
    else
      pend_next = p;
  endfunction

  function automatic logic pend_drop(input logic [PEND_W-1:0] p,
                                     input logic e, input logic d);
    pend_drop = e && !d && (p == PEND_MAX);
  endfunction

  // Rotating priority search starting just after the last-granted source.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = SEL_W'((int'(lg) + k) % NREQ);
      if (!found && pending[idx] != '0) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    drain     = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt   = READ;
          drain[pick] = 1'b1;
        end
      end
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge R_n) begin
    if (!R_n) begin
      state <= IDLE;
      grant <= '0;
      cur   <= '0;
      lg    <= LG_INIT;
      acc   <= '0;
      ovf   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        pending[i] <= '0;
        cnt[i]     <= '0;
      end
    end else if (clr) begin
      // Abandons any in-flight update; same-cycle events are discarded.
      state <= IDLE;
      grant <= '0;
      cur   <= '0;
      lg    <= LG_INIT;
      acc   <= '0;
      ovf   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        pending[i] <= '0;
        cnt[i]     <= '0;
      end
    end else begin
      state <= state_nxt;
      for (int i = 0; i < NREQ; i++) begin
        pending[i] <= pend_next(pending[i], ev[i], drain[i]);
        if (pend_drop(pending[i], ev[i], drain[i]))
          ovf[i] <= 1'b1;
      end
      case (state)
        // IDLE -> READ: latch the granted source
        IDLE: begin
          if (found) begin
            cur   <= pick;
            grant <= NREQ'(1) << pick;
          end
        end
        // READ -> WRITE: increment with wrap
        READ: acc <= cnt[cur] + CNT_W'(1);
        // WRITE -> IDLE: commit and advance the round-robin pointer
        WRITE: begin
          cnt[cur] <= acc;
          if (acc == '0)
            ovf[cur] <= 1'b1;
          lg    <= cur;
          grant <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Pad the read table so out-of-range selects return zero.
  for (genvar j = 0; j < 2**SEL_W; j++) begin : g_rd
    if (j < NREQ) begin : g_live
      assign rd_tab[j] = cnt[j];
    end else begin : g_pad
      assign rd_tab[j] = '0;
    end
  end

  assign rd_data = rd_tab[rd_sel];

endmodule

// File: tb/tb_pwr_event_sched.sv
module tb_pwr_event_sched;

  localparam int NREQ   = 4;
  localparam int CNT_W  = 4;
  localparam int PEND_W = 3;
  localparam int SEL_W  = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;
  localparam int CMOD   = 1 << CNT_W;

  logic              C = 1'b0;
  logic              R_n = 1'b0;
  logic              clr = 1'b0;
  logic [NREQ-1:0]   ev = '0;
  logic [SEL_W-1:0]  rd_sel = '0;
  logic [CNT_W-1:0]  rd_data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ovf;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Reference state: queued events per source, counter values, overflow
  // flags, service phase (0 idle, 1 reading, 2 writing), source in service.
  int              m_pend [NREQ];
  int              m_cnt  [NREQ];
  logic [NREQ-1:0] m_ovf;
  int              m_phase;
  int              m_cur;
  int              m_lg;
  int              m_acc;

  pwr_event_sched #(
    .NREQ   (NREQ),
    .CNT_W  (CNT_W),
    .PEND_W (PEND_W),
    .SEL_W  (SEL_W)
  ) dut (
    .C       (C),
    .R_n     (R_n),
    .ev      (ev),
    .clr     (clr),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .grant   (grant),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #10 C = ~C;

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) begin
      m_pend[i] = 0;
      m_cnt[i]  = 0;
    end
    m_ovf   = '0;
    m_phase = 0;
    m_cur   = 0;
    m_lg    = NREQ - 1;
    m_acc   = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] e, input logic c);
    int served;
    served = -1;
    if (c) begin
      model_reset();
      return;
    end
    if (m_phase == 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (served < 0 && m_pend[(m_lg + k) % NREQ] > 0)
          served = (m_lg + k) % NREQ;
      end
      if (served >= 0) begin
        m_cur   = served;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_acc   = (m_cnt[m_cur] + 1) % CMOD;
      m_phase = 2;
    end else begin
      m_cnt[m_cur] = m_acc;
      if (m_acc == 0) m_ovf[m_cur] = 1'b1;
      m_lg    = m_cur;
      m_phase = 0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (e[i] && served != i) begin
        if (m_pend[i] == PMAX) m_ovf[i] = 1'b1;
        else m_pend[i]++;
      end else if (!e[i] && served == i) begin
        m_pend[i]--;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("grant", 32'(grant), (m_phase != 0) ? (32'd1 << m_cur) : 32'd0);
    chk("busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
    chk("ovf", 32'(ovf), 32'(m_ovf));
    for (int i = 0; i < NREQ; i++) begin
      rd_sel = SEL_W'(i);
      #1;
      chk($sformatf("cnt%0d", i), 32'(rd_data), 32'(m_cnt[i]));
    end
  endtask

  // Drive at the falling edge, sample a little after the rising edge.
  task automatic cycle(input logic [NREQ-1:0] e, input logic c);
    ev  = e;
    clr = c;
    @(posedge C);
    if (R_n) model_step(e, c);
    else model_reset();
    #1;
    check_all();
    @(negedge C);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, 1'b0);
  endtask

  task automatic pulse_reset();
    ev  = '0;
    clr = 1'b0;
    R_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge C);
    R_n = 1'b1;
  endtask

  task automatic build_cnt0(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(4'b0001, 1'b0);
      idle(2);
    end
    idle(3);
  endtask

  initial begin
    model_reset();
    @(negedge C);
    check_all();
    @(negedge C);
    R_n = 1'b1;

    // Idle after reset
    idle(10);

    // Single event on source 2
    cycle(4'b0100, 1'b0);
    idle(5);
    chk("single_cnt2_direct", 32'(dut.cnt[2]), 32'd1);

    // Round-robin across all sources
    cycle(4'b1111, 1'b0);
    idle(14);

    // Pending saturation on source 1, then drain
    for (int i = 0; i < 12; i++) cycle(4'b0010, 1'b0);
    chk("sat_ovf1", 32'(ovf[1]), 32'd1);
    idle(40);

    // Counter wrap on source 3
    cycle('0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      cycle(4'b1000, 1'b0);
      idle(2);
    end
    idle(4);
    chk("wrap_ovf3", 32'(ovf[3]), 32'd1);

    // clr while reading source 0 with cnt[0]=5
    cycle('0, 1'b1);
    build_cnt0(5);
    cycle(4'b0001, 1'b0);
    cycle('0, 1'b0);
    chk("pre_clr_busy", 32'(busy), 32'd1);
    cycle('0, 1'b1);
    idle(3);

    // Same, with an asynchronous reset pulse instead
    build_cnt0(5);
    cycle(4'b0001, 1'b0);
    cycle('0, 1'b0);
    pulse_reset();
    idle(3);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      logic [NREQ-1:0] e;
      logic c;
      e = NREQ'($urandom_range(0, 15) & $urandom_range(0, 15));
      c = ($urandom_range(0, 63) == 0);
      cycle(e, c);
    end
    idle(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
